max_sort_engine: RTL

Sequential, parametrised successor to the combinational max-select slice in the `max_sort` tree. It accepts a frame of M N-bit words with a participation mask through a valid/ready handshake. It then emits the enabled words in sorted order, largest first, one per output handshake, using MSB-first bit-serial elimination. It sits between the loader and the downstream consumer of sorted keys and is the first `max_sort` block with state, backpressure and configurable width/depth.

---
 rtl/sort_pkg.sv | 13 +
 rtl/prio_first.sv | 24 ++
 rtl/max_sort_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and default geometry for the max_sort family.
package sort_pkg;

    localparam int unsigned M = 8;
    localparam int unsigned N = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_OUT
    } ms_state_t;

endpackage

// File: rtl/prio_first.sv
// Lowest-set-bit selector: one-hot grant plus binary index of the first request.
module prio_first #(
    parameter int unsigned M  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [M-1:0]  req,
    output logic [M-1:0]  onehot_c,
    output logic [IW-1:0] idx_c
);

    // Scan from the top so the lowest requesting index is the last one written.
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (req[k]) begin
                onehot_c    = '0;
                onehot_c[k] = 1'b1;
                idx_c       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/max_sort_engine.sv
// Sequential bit-serial sorter: emits the masked words of a frame largest first
// (smallest first when MAX_SORT_MODE_EN is defined and i_ascend is set).
// Optional feature macro: MAX_SORT_MODE_EN.
module max_sort_engine #(
    parameter  int unsigned M  = sort_pkg::M,
    parameter  int unsigned N  = sort_pkg::N,
    localparam int unsigned IW = $clog2(M)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [M-1:0][N-1:0] i_chi,
    input  logic [M-1:0]        i_h,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [N-1:0]        o_y,
    output logic [IW-1:0]       o_idx,
    output logic                o_last,
    output logic                o_done
`ifdef MAX_SORT_MODE_EN
    ,
    input  logic                i_ascend
`endif
);

    import sort_pkg::*;

    localparam int unsigned QW = (N > 1) ? $clog2(N) : 1;

    ms_state_t            state, state_nxt;
    logic [M-1:0][N-1:0]  words, words_nxt;
    logic [M-1:0]         remain, remain_nxt;
    logic [M-1:0]         cand, cand_nxt;
    logic [QW-1:0]        q, q_nxt;
    logic                 valid_nxt, last_nxt, done_nxt;
    logic [N-1:0]         y_nxt;
    logic [IW-1:0]        idx_nxt;

    logic [M-1:0]         col_c;
    logic [M-1:0]         elim_c;
    logic [M-1:0]         cand_scan_c;
    logic [M-1:0]         win_oh_c;
    logic [IW-1:0]        win_idx_c;
    logic [N-1:0]         win_y_c;
    logic [M-1:0]         remain_clr_c;
    logic                 single_c;

`ifdef MAX_SORT_MODE_EN
    logic                 ascend, ascend_nxt;
`endif

    // Readiness depends on state only.
    assign o_ready = (state == S_IDLE);

    // Bit column q across all stored words.
    always_comb begin
        col_c = '0;
        for (int k = 0; k < M; k++) begin
            col_c[k] = words[k][q];
        end
    end

    // One elimination step; keep the candidate set if nobody survives.
`ifdef MAX_SORT_MODE_EN
    assign elim_c = ascend ? (cand & ~col_c) : (cand & col_c);
`else
    assign elim_c = cand & col_c;
`endif
    assign cand_scan_c  = (|elim_c) ? elim_c : cand;
    assign remain_clr_c = remain & ~(M'(1) << o_idx);
    assign single_c     = ((remain & (remain - M'(1))) == '0);

    prio_first #(
        .M  (M),
        .IW (IW)
    ) u_prio_first (
        .req      (cand_scan_c),
        .onehot_c (win_oh_c),
        .idx_c    (win_idx_c)
    );

    // Winner word select from the one-hot grant.
    always_comb begin
        win_y_c = '0;
        for (int k = 0; k < M; k++) begin
            if (win_oh_c[k]) begin
                win_y_c = win_y_c | words[k];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        words_nxt  = words;
        remain_nxt = remain;
        cand_nxt   = cand;
        q_nxt      = q;
        valid_nxt  = o_valid;
        y_nxt      = o_y;
        idx_nxt    = o_idx;
        last_nxt   = o_last;
        done_nxt   = 1'b0;
`ifdef MAX_SORT_MODE_EN
        ascend_nxt = ascend;
`endif
        unique case (state)
            S_IDLE: begin
                if (i_valid) begin
                    words_nxt  = i_chi;
                    remain_nxt = i_h;
`ifdef MAX_SORT_MODE_EN
                    ascend_nxt = i_ascend;
`endif
                    if (i_h == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        cand_nxt  = i_h;
                        q_nxt     = QW'(N - 1);
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                cand_nxt = cand_scan_c;
                q_nxt    = q - QW'(1);
                if (q == '0) begin
                    state_nxt = S_OUT;
                    valid_nxt = 1'b1;
                    y_nxt     = win_y_c;
                    idx_nxt   = win_idx_c;
                    last_nxt  = single_c;
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    valid_nxt  = 1'b0;
                    y_nxt      = '0;
                    idx_nxt    = '0;
                    last_nxt   = 1'b0;
                    remain_nxt = remain_clr_c;
                    if (o_last) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cand_nxt  = remain_clr_c;
                        q_nxt     = QW'(N - 1);
                        state_nxt = S_SCAN;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            words   <= '0;
            remain  <= '0;
            cand    <= '0;
            q       <= '0;
            o_valid <= 1'b0;
            o_y     <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
`ifdef MAX_SORT_MODE_EN
            ascend  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            words   <= words_nxt;
            remain  <= remain_nxt;
            cand    <= cand_nxt;
            q       <= q_nxt;
            o_valid <= valid_nxt;
            o_y     <= y_nxt;
            o_idx   <= idx_nxt;
            o_last  <= last_nxt;
            o_done  <= done_nxt;
`ifdef MAX_SORT_MODE_EN
            ascend  <= ascend_nxt;
`endif
        end
    end

endmodule
